demux1x2_stream: RTL
====================

// Module: demux1x2_stream
// PURPOSE
//   Registered 1-to-2 demultiplexer for the 32-bit ALU datapath: inverse of the 2:1 word mux.
//   Accepts one data word per cycle on a valid/ready input and steers it by select S to output 0 or 1.
//   Each output has its own small FIFO so one stalled consumer does not block the other path.
//   Per-output delivery counters support debug and bench scoreboarding.
// PARAMETERS
//   WIDTH  32  data word width
//   DEPTH  2   entries per output FIFO; power of 2, >= 2
//   CNT_W  8   width of per-output delivered-word counters
// PORTS
//   clk       in   1      rising-edge clock, sole clock domain
//   rst_n     in   1      asynchronous, active-low reset
//   D         in   WIDTH  input data word
//   S         in   1      route select: 0 -> output 0, 1 -> output 1
//   in_valid  in   1      D/S valid
//   in_ready  out  1      block can accept D on this cycle
//   F0        out  WIDTH  output 0 head word
//   f0_valid  out  1      F0 holds a buffered word
//   f0_ready  in   1      consumer 0 takes F0
//   F1        out  WIDTH  output 1 head word
//   f1_valid  out  1      F1 holds a buffered word
//   f1_ready  in   1      consumer 1 takes F1
//   cnt0      out  CNT_W  words delivered on output 0, mod 2^CNT_W
//   cnt1      out  CNT_W  words delivered on output 1, mod 2^CNT_W
// BEHAVIOUR
//   Reset (async assert, sync-to-clk deassert by upstream): FIFO pointers/occupancy, cnt0, cnt1 -> 0;
//     f0_valid=f1_valid=0, F0=F1=0, in_ready=1 once reset released. Storage RAM is not reset.
//   Reset mid-operation discards all buffered words; no partial output after reset.
//   Accept: push when in_valid & in_ready, into FIFO[S]. in_ready = ~full[S]
//     (combinational in S and occupancy only; NO combinational path from f0_ready/f1_ready).
//   Full FIFO: push blocked even if the same FIFO pops in that cycle.
//   Upstream holds D and S stable while in_valid=1 and in_ready=0; S change before accept re-evaluates in_ready.
//   Latency: word accepted at edge N appears on F[S] with f[S]_valid=1 after edge N (1 cycle); no bypass.
//   Output side: first-word-fall-through; F_i = FIFO_i head when f_i_valid=1, else F_i = 0.
//     Pop on f_i_valid & f_i_ready; f_i_ready ignored when f_i_valid=0.
//   Simultaneous push and pop on the same non-full FIFO: both occur, occupancy unchanged.
//   Both FIFOs may pop in the same cycle, independently of push.
//   Ordering: strict FIFO order per output; no ordering guarantee between outputs.
//   Pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits, full when == DEPTH.
//   cnt_i increments by 1 on each pop of output i, wraps 2^CNT_W-1 -> 0 silently.
//   No X propagation: with in_valid=0, D/S values never affect state.
// TESTING
//   T1 reset: hold rst_n=0 with random inputs -> f0_valid=f1_valid=0, F0=F1=0, cnt0=cnt1=0; release -> in_ready=1.
//   T2 routing: push 0xDEADBEEF S=0, then 0x12345678 S=1, both readys=1 -> F0=0xDEADBEEF one cycle after its accept,
//      F1=0x12345678 one cycle after its accept; cnt0=1, cnt1=1.
//   T3 backpressure: f0_ready=0, push 3 words S=0 (DEPTH=2) -> 2 accepted, in_ready=0 for S=0 while in_ready=1 for S=1;
//      push 0xA5A5A5A5 S=1 accepted and delivered on F1 while output 0 stays stalled.
//   T4 full + pop same cycle: FIFO0 full, f0_ready=1 with in_valid=1 S=0 -> pop happens, push refused that cycle,
//      accepted next cycle; F0 order = 0x1, 0x2, 0x3.
//   T5 wrap: stream 300 words alternating S, readys=1 -> cnt0=cnt1=150 mod 256 = 150; pointer wrap, no loss/reorder.
//   T6 reset mid-stream: assert rst_n=0 with both FIFOs holding words -> immediate f*_valid=0, counters 0; post-reset
//      first push 0x00000001 S=1 is the first word seen on F1.

Source files
------------

// File: rtl/demux1x2_stream.sv
// rtl/demux1x2_stream.sv - registered 1:2 stream demux with per-output FWFT FIFOs and delivery counters
module demux1x2_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             S,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] F0,
  output logic             f0_valid,
  input  logic             f0_ready,
  output logic [WIDTH-1:0] F1,
  output logic             f1_valid,
  input  logic             f1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW:0]      occ_q  [2];
  logic [AW:0]      occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  // in_ready depends only on S and occupancy, so a same-cycle pop never frees a full FIFO
  always_comb begin
    out_ready = {f1_ready, f0_ready};
    for (int i = 0; i < 2; i++) begin
      full[i]  = (occ_q[i] == (AW+1)'(DEPTH));
      valid[i] = (occ_q[i] != '0);
      pop[i]   = valid[i] & out_ready[i];
    end
    in_ready = ~full[S];
    for (int i = 0; i < 2; i++) begin
      push[i]  = in_valid & in_ready & (S == 1'(i));
      occ_d[i] = occ_q[i];
      case ({push[i], pop[i]})
        2'b10:   occ_d[i] = occ_q[i] + (AW+1)'(1);
        2'b01:   occ_d[i] = occ_q[i] - (AW+1)'(1);
        default: occ_d[i] = occ_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        occ_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        occ_q[i] <= occ_d[i];
        if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop[i]) begin
          rptr_q[i] <= rptr_q[i] + AW'(1);
          cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Storage is deliberately left out of reset; occupancy alone gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= D;
    end
  end

  assign f0_valid = valid[0];
  assign f1_valid = valid[1];
  assign F0       = valid[0] ? mem_q[0][rptr_q[0]] : '0;
  assign F1       = valid[1] ? mem_q[1][rptr_q[1]] : '0;
  assign cnt0     = cnt_q[0];
  assign cnt1     = cnt_q[1];

endmodule
